// File: rtl/axis_window_pkg.sv
// Shared constants and types for the window-stream arbiter and its round-robin picker.
package axis_window_pkg;

  localparam int DATA_WIDTH_DEF = 128;
  localparam int DROP_CNT_W     = 16;
  localparam int MAX_IDX_W      = 4;

  typedef logic [MAX_IDX_W-1:0] port_idx_t;

endpackage

// File: rtl/axis_window_rr_pick.sv
// Combinational round-robin search: the first request above ptr wins, wrapping back to index 0.
module axis_window_rr_pick
  import axis_window_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic [IDX_WIDTH-1:0] grant,
  output logic                 any_grant
);

  logic found_hi;
  logic found_lo;
  logic [IDX_WIDTH-1:0] grant_hi;
  logic [IDX_WIDTH-1:0] grant_lo;

  // Ports above ptr take priority; otherwise the wrapped range 0..ptr is searched.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    grant_hi = '0;
    grant_lo = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (req[i] && (i > int'(ptr)) && !found_hi) begin
        found_hi = 1'b1;
        grant_hi = IDX_WIDTH'(i);
      end
      if (req[i] && (i <= int'(ptr)) && !found_lo) begin
        found_lo = 1'b1;
        grant_lo = IDX_WIDTH'(i);
      end
    end
    any_grant = found_hi | found_lo;
    grant     = found_hi ? grant_hi : grant_lo;
  end

endmodule

// File: rtl/axis_window_arbiter.sv
// Round-robin merge of NUM_PORTS backpressure-free window streams onto one AXI4-Stream output.
// Optional per-port saturating drop counters are enabled by defining AXIS_WINDOW_ARB_CNT_EN.
module axis_window_arbiter
  import axis_window_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IDX_WIDTH  = 2
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [NUM_PORTS-1:0]            cfg_enbl,
  input  logic                            ovf_clr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [IDX_WIDTH-1:0]            m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [NUM_PORTS-1:0]            sts_ovf
`ifdef AXIS_WINDOW_ARB_CNT_EN
  ,
  output logic [NUM_PORTS*DROP_CNT_W-1:0] sts_drop_cntr
`endif
);

  logic [NUM_PORTS-1:0]  full;
  logic [DATA_WIDTH-1:0] buf_data [NUM_PORTS];
  logic [NUM_PORTS-1:0]  req;
  logic [NUM_PORTS-1:0]  pop;
  logic [NUM_PORTS-1:0]  push;
  logic [NUM_PORTS-1:0]  drop;
  logic [IDX_WIDTH-1:0]  ptr;
  logic [IDX_WIDTH-1:0]  grant;
  logic                  any_grant;
  logic                  out_free;

  axis_window_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_pick (
    .req       (req),
    .ptr       (ptr),
    .grant     (grant),
    .any_grant (any_grant)
  );

  // Disabled ports are masked from arbitration so a stale word can never be granted.
  always_comb begin
    out_free = ~m_axis_tvalid | m_axis_tready;
    req      = full & cfg_enbl;
    pop      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      pop[i] = out_free & any_grant & (grant == IDX_WIDTH'(i));
    end
    push = s_axis_tvalid & cfg_enbl & (~full | pop);
    drop = s_axis_tvalid & cfg_enbl & full & ~pop;
  end

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_buf
    always_ff @(posedge aclk) begin
      if (!aresetn) begin
        full[gi]     <= 1'b0;
        buf_data[gi] <= '0;
      end else if (!cfg_enbl[gi]) begin
        full[gi] <= 1'b0;
      end else if (push[gi]) begin
        full[gi]     <= 1'b1;
        buf_data[gi] <= s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
      end else if (pop[gi]) begin
        full[gi] <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      ptr           <= IDX_WIDTH'(NUM_PORTS - 1);
    end else if (out_free) begin
      m_axis_tvalid <= any_grant;
      if (any_grant) begin
        m_axis_tdata <= buf_data[grant];
        m_axis_tuser <= grant;
        ptr          <= grant;
      end
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      sts_ovf <= '0;
    end else begin
      sts_ovf <= (sts_ovf & ~{NUM_PORTS{ovf_clr}}) | drop;
    end
  end

`ifdef AXIS_WINDOW_ARB_CNT_EN
  for (genvar gc = 0; gc < NUM_PORTS; gc++) begin : g_cnt
    logic [DROP_CNT_W-1:0] cnt;

    always_ff @(posedge aclk) begin
      if (!aresetn) begin
        cnt <= '0;
      end else if (ovf_clr) begin
        cnt <= drop[gc] ? DROP_CNT_W'(1) : '0;
      end else if (drop[gc] && (cnt != {DROP_CNT_W{1'b1}})) begin
        cnt <= cnt + DROP_CNT_W'(1);
      end
    end

    assign sts_drop_cntr[gc*DROP_CNT_W +: DROP_CNT_W] = cnt;
  end
`endif

endmodule

// File: tb/tb_axis_window_arbiter.sv
// Directed bench for axis_window_arbiter: a vector table plus hand-written stall/disable/counter sequences.
module tb_axis_window_arbiter;

  localparam int NP = 4;
  localparam int DW = 128;
  localparam int IW = 2;

  logic             aclk;
  logic             aresetn;
  logic [NP-1:0]    cfg_enbl;
  logic             ovf_clr;
  logic [NP*DW-1:0] s_axis_tdata;
  logic [NP-1:0]    s_axis_tvalid;
  logic [DW-1:0]    m_axis_tdata;
  logic [IW-1:0]    m_axis_tuser;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic [NP-1:0]    sts_ovf;
`ifdef AXIS_WINDOW_ARB_CNT_EN
  logic [NP*16-1:0] sts_drop_cntr;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  axis_window_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_enbl      (cfg_enbl),
    .ovf_clr       (ovf_clr),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .sts_ovf       (sts_ovf)
`ifdef AXIS_WINDOW_ARB_CNT_EN
    ,
    .sts_drop_cntr (sts_drop_cntr)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] d0, d1, d2, d3;
    logic        rdy;
    logic [3:0]  en;
    logic        clr;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [1:0]  exp_user;
    logic [3:0]  exp_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [3:0] v, input logic [31:0] d0, input logic [31:0] d1,
                     input logic [31:0] d2, input logic [31:0] d3, input logic rdy, input logic clr,
                     input logic ev, input logic [31:0] ed, input logic [1:0] eu, input logic [3:0] eo);
    vecs.push_back('{rst, v, d0, d1, d2, d3, rdy, 4'hF, clr, ev, ed, eu, eo});
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] d3, input logic rdy, input logic [3:0] en, input logic clr);
    s_axis_tvalid          = v;
    s_axis_tdata[0*DW+:DW] = 128'(d0);
    s_axis_tdata[1*DW+:DW] = 128'(d1);
    s_axis_tdata[2*DW+:DW] = 128'(d2);
    s_axis_tdata[3*DW+:DW] = 128'(d3);
    m_axis_tready          = rdy;
    cfg_enbl               = en;
    ovf_clr                = clr;
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    drive(4'h0, 0, 0, 0, 0, 1'b1, 4'hF, 1'b0);
    aresetn = 1'b0;
    cyc();
    aresetn = 1'b1;
  endtask

  initial begin
    aresetn = 1'b0;
    drive(4'h0, 0, 0, 0, 0, 1'b1, 4'hF, 1'b0);
    s_axis_tdata = '0;
    cyc();

    // Single word latency (inputs applied, one edge, then expectations)
    add(1, 4'b0000, 0,     0, 0, 0, 1, 0, 0, 0,     0, 4'b0000);
    add(0, 4'b0001, 'hA5,  0, 0, 0, 1, 0, 0, 0,     0, 4'b0000);
    add(0, 4'b0000, 0,     0, 0, 0, 1, 0, 1, 'hA5,  0, 4'b0000);
    add(0, 4'b0000, 0,     0, 0, 0, 1, 0, 0, 0,     0, 4'b0000);
    // All four ports at once
    add(1, 4'b0000, 0,     0, 0, 0, 1, 0, 0, 0,     0, 4'b0000);
    add(0, 4'b1111, 1,     2, 3, 4, 1, 0, 0, 0,     0, 4'b0000);
    add(0, 4'b0000, 0,     0, 0, 0, 1, 0, 1, 1,     0, 4'b0000);
    add(0, 4'b0000, 0,     0, 0, 0, 1, 0, 1, 2,     1, 4'b0000);
    add(0, 4'b0000, 0,     0, 0, 0, 1, 0, 1, 3,     2, 4'b0000);
    add(0, 4'b0000, 0,     0, 0, 0, 1, 0, 1, 4,     3, 4'b0000);
    add(0, 4'b0000, 0,     0, 0, 0, 1, 0, 0, 0,     0, 4'b0000);
    // Ports 0 and 1 streaming every cycle; clear coinciding with a port-0 drop
    add(1, 4'b0000, 0,     0,     0, 0, 1, 0, 0, 0,     0, 4'b0000);
    add(0, 4'b0011, 'h101, 'h201, 0, 0, 1, 0, 0, 0,     0, 4'b0000);
    add(0, 4'b0011, 'h102, 'h202, 0, 0, 1, 0, 1, 'h101, 0, 4'b0010);
    add(0, 4'b0011, 'h103, 'h203, 0, 0, 1, 0, 1, 'h201, 1, 4'b0011);
    add(0, 4'b0011, 'h104, 'h204, 0, 0, 1, 0, 1, 'h102, 0, 4'b0011);
    add(0, 4'b0011, 'h105, 'h205, 0, 0, 1, 0, 1, 'h203, 1, 4'b0011);
    add(0, 4'b0011, 'h106, 'h206, 0, 0, 1, 0, 1, 'h104, 0, 4'b0011);
    add(0, 4'b0011, 'h107, 'h207, 0, 0, 1, 1, 1, 'h205, 1, 4'b0001);
    add(0, 4'b0000, 0,     0,     0, 0, 1, 0, 1, 'h106, 0, 4'b0001);
    add(0, 4'b0000, 0,     0,     0, 0, 1, 0, 1, 'h207, 1, 4'b0001);
    add(0, 4'b0000, 0,     0,     0, 0, 1, 0, 0, 0,     0, 4'b0001);

    foreach (vecs[k]) begin
      drive(vecs[k].valid, vecs[k].d0, vecs[k].d1, vecs[k].d2, vecs[k].d3, vecs[k].rdy, vecs[k].en, vecs[k].clr);
      aresetn = ~vecs[k].rst;
      cyc();
      chk($sformatf("row%0d tvalid", k), 128'(m_axis_tvalid), 128'(vecs[k].exp_valid));
      chk($sformatf("row%0d sts_ovf", k), 128'(sts_ovf), 128'(vecs[k].exp_ovf));
      if (vecs[k].exp_valid || vecs[k].rst) begin
        chk($sformatf("row%0d tdata", k), m_axis_tdata, 128'(vecs[k].exp_data));
        chk($sformatf("row%0d tuser", k), 128'(m_axis_tuser), 128'(vecs[k].exp_user));
      end
    end
    aresetn = 1'b1;

    // Stall: output holds 5, buffer holds 6, third word 7 is dropped
    do_reset();
    drive(4'b0100, 0, 0, 5, 0, 1'b0, 4'hF, 1'b0); cyc();
    chk("stall first tvalid", 128'(m_axis_tvalid), 128'(0));
    drive(4'b0100, 0, 0, 6, 0, 1'b0, 4'hF, 1'b0); cyc();
    chk("stall hold tvalid", 128'(m_axis_tvalid), 128'(1));
    chk("stall hold tdata", m_axis_tdata, 128'(5));
    chk("stall hold tuser", 128'(m_axis_tuser), 128'(2));
    chk("stall no drop yet", 128'(sts_ovf), 128'(0));
    drive(4'b0100, 0, 0, 7, 0, 1'b0, 4'hF, 1'b0); cyc();
    chk("stall still tdata", m_axis_tdata, 128'(5));
    chk("stall drop ovf", 128'(sts_ovf), 128'(4'b0100));
    drive(4'b0000, 0, 0, 0, 0, 1'b1, 4'hF, 1'b0); cyc();
    chk("release tvalid", 128'(m_axis_tvalid), 128'(1));
    chk("release tdata", m_axis_tdata, 128'(6));
    chk("release tuser", 128'(m_axis_tuser), 128'(2));
    cyc();
    chk("release drained", 128'(m_axis_tvalid), 128'(0));
    chk("release ovf", 128'(sts_ovf), 128'(4'b0100));

    // Disable a buffered port before it is granted
    do_reset();
    drive(4'b1000, 0, 0, 0, 'h33, 1'b1, 4'hF, 1'b0); cyc();
    chk("dis buffered tvalid", 128'(m_axis_tvalid), 128'(0));
    drive(4'b0000, 0, 0, 0, 0, 1'b1, 4'b0111, 1'b0); cyc();
    chk("dis no grant", 128'(m_axis_tvalid), 128'(0));
    drive(4'b1000, 0, 0, 0, 'h34, 1'b1, 4'b0111, 1'b0); cyc();
    chk("dis ignored in", 128'(m_axis_tvalid), 128'(0));
    drive(4'b0000, 0, 0, 0, 0, 1'b1, 4'hF, 1'b0); cyc();
    chk("dis reenable empty", 128'(m_axis_tvalid), 128'(0));
    cyc();
    chk("dis still empty", 128'(m_axis_tvalid), 128'(0));
    chk("dis no ovf", 128'(sts_ovf), 128'(0));

`ifdef AXIS_WINDOW_ARB_CNT_EN
    // Drop counter: small count, saturation, clear, clear-with-drop
    do_reset();
    drive(4'b0010, 0, 9, 0, 0, 1'b0, 4'hF, 1'b0);
    repeat (5) cyc();
    chk("cnt three drops", 128'(sts_drop_cntr[31:16]), 128'(3));
    chk("cnt other port", 128'(sts_drop_cntr[15:0]), 128'(0));
    repeat (70000) cyc();
    chk("cnt saturated", 128'(sts_drop_cntr[31:16]), 128'(16'hFFFF));
    drive(4'b0000, 0, 0, 0, 0, 1'b0, 4'hF, 1'b1); cyc();
    chk("cnt cleared", 128'(sts_drop_cntr[31:16]), 128'(0));
    drive(4'b0010, 0, 9, 0, 0, 1'b0, 4'hF, 1'b1); cyc();
    chk("cnt clear and drop", 128'(sts_drop_cntr[31:16]), 128'(1));
    drive(4'b0000, 0, 0, 0, 0, 1'b1, 4'hF, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
